// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle RV32I control unit: states, opcodes and mux selects.
package mcu_pkg;

    typedef logic [2:0] mcu_state_t;

    localparam mcu_state_t StFetch  = 3'd0;
    localparam mcu_state_t StDecode = 3'd1;
    localparam mcu_state_t StExec   = 3'd2;
    localparam mcu_state_t StMem    = 3'd3;
    localparam mcu_state_t StWb     = 3'd4;
    localparam mcu_state_t StHalt   = 3'd5;
    localparam mcu_state_t StTrap   = 3'd6;

    localparam logic [4:0] OpcR      = 5'b01100;
    localparam logic [4:0] OpcLoad   = 5'b00000;
    localparam logic [4:0] OpcIarith = 5'b00100;
    localparam logic [4:0] OpcStore  = 5'b01000;
    localparam logic [4:0] OpcBranch = 5'b11000;
    localparam logic [4:0] OpcLui    = 5'b01101;
    localparam logic [4:0] OpcAuipc  = 5'b00101;
    localparam logic [4:0] OpcJal    = 5'b11011;
    localparam logic [4:0] OpcJalr   = 5'b11001;

    localparam logic [1:0] PcSelPlus4  = 2'b00;
    localparam logic [1:0] PcSelTarget = 2'b01;
    localparam logic [1:0] PcSelAlu    = 2'b10;

    localparam logic [1:0] WbSelAlu = 2'b00;
    localparam logic [1:0] WbSelMem = 2'b01;
    localparam logic [1:0] WbSelImm = 2'b10;
    localparam logic [1:0] WbSelPc4 = 2'b11;

    function automatic logic [1:0] wb_sel_for(input logic [4:0] opc);
        case (opc)
            OpcLoad:         return WbSelMem;
            OpcLui:          return WbSelImm;
            OpcJal, OpcJalr: return WbSelPc4;
            default:         return WbSelAlu;
        endcase
    endfunction

endpackage

// File: rtl/mcu_mem_timeout.sv
// Memory-wait watchdog: counts stalled request cycles and strobes when the limit is reached.
module mcu_mem_timeout #(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TO_CNT_W    = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam logic [TO_CNT_W:0] Limit = (TO_CNT_W + 1)'(MEM_TIMEOUT);
    localparam logic [TO_CNT_W:0] One   = (TO_CNT_W + 1)'(1);

    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_CNT_W:0]   cnt_inc;
    logic                waiting;

    assign waiting = req_i & ~ready_i;
    assign cnt_inc = {1'b0, cnt_q} + One;

    // Any cycle without a stalled request (idle state or accepted transfer) restarts the count.
    always_comb begin
        cnt_d = '0;
        if (waiting) begin
            cnt_d = cnt_inc[TO_CNT_W] ? cnt_q : cnt_inc[TO_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (MEM_TIMEOUT != 0) && waiting && (cnt_inc >= Limit);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory timeout and sticky halt.
// Define MCU_ILLEGAL_TRAP_EN to route unknown opcodes through a TRAP state with illegal_o.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned OPC_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TO_CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             branch_taken_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_addr_sel_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_sel_o,
    output logic             alu_a_sel_o,
    output logic             alu_b_sel_o,
    output logic             reg_we_o,
    output logic [1:0]       wb_sel_o,
    output logic             instret_o,
    output logic             err_o,
`ifdef MCU_ILLEGAL_TRAP_EN
    output logic             illegal_o,
`endif
    output logic [2:0]       state_o
);

    mcu_state_t state_q, state_d;
    logic       err_q, err_d;
    logic       timeout;
    logic [4:0] opc;

    assign opc = opcode_i;

    mcu_mem_timeout #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_CNT_W   (TO_CNT_W)
    ) u_mem_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (mem_req_o),
        .ready_i  (mem_ready_i),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d        = state_q;
        err_d          = err_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_sel_o       = PcSelPlus4;
        alu_a_sel_o    = 1'b0;
        alu_b_sel_o    = 1'b0;
        reg_we_o       = 1'b0;
        wb_sel_o       = WbSelAlu;
        instret_o      = 1'b0;
`ifdef MCU_ILLEGAL_TRAP_EN
        illegal_o      = 1'b0;
`endif
        case (state_q)
            StFetch: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                case (opc)
                    OpcR:      state_d = StWb;
                    OpcIarith: begin
                        alu_b_sel_o = 1'b1;
                        state_d     = StWb;
                    end
                    OpcLoad, OpcStore: begin
                        alu_b_sel_o = 1'b1;
                        state_d     = StMem;
                    end
                    OpcLui:    state_d = StWb;
                    OpcAuipc: begin
                        alu_a_sel_o = 1'b1;
                        alu_b_sel_o = 1'b1;
                        state_d     = StWb;
                    end
                    OpcBranch: begin
                        pc_we_o   = branch_taken_i;
                        pc_sel_o  = PcSelTarget;
                        instret_o = 1'b1;
                        state_d   = StFetch;
                    end
                    OpcJal: begin
                        pc_we_o  = 1'b1;
                        pc_sel_o = PcSelTarget;
                        state_d  = StWb;
                    end
                    OpcJalr: begin
                        alu_b_sel_o = 1'b1;
                        pc_we_o     = 1'b1;
                        pc_sel_o    = PcSelAlu;
                        state_d     = StWb;
                    end
                    default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                        state_d   = StTrap;
`else
                        // PC already advanced in FETCH, so retiring here makes it a NOP.
                        instret_o = 1'b1;
                        state_d   = StFetch;
`endif
                    end
                endcase
            end
            StMem: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = (opc == OpcStore);
                alu_b_sel_o    = 1'b1;
                if (mem_ready_i) begin
                    if (opc == OpcStore) begin
                        instret_o = 1'b1;
                        state_d   = StFetch;
                    end else begin
                        state_d   = StWb;
                    end
                end else if (timeout) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end
            end
            StWb: begin
                reg_we_o  = 1'b1;
                wb_sel_o  = wb_sel_for(opc);
                instret_o = 1'b1;
                state_d   = StFetch;
            end
            StHalt: ;
`ifdef MCU_ILLEGAL_TRAP_EN
            StTrap: begin
                pc_we_o   = 1'b1;
                pc_sel_o  = PcSelAlu;
                illegal_o = 1'b1;
                state_d   = StFetch;
            end
`endif
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFetch;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign err_o   = err_q;
    assign state_o = state_q;

endmodule
